adc_buffer_scheduler: RTL and testbench

- Shares the 4 capture-buffer AXI4-Stream inputs among the 8 RFDC ADC output streams, all in the aclk domain.
- Latches per-channel capture requests and grants each free buffer slot to a channel in round-robin order.
- Optionally aligns the start of each capture to the PL-registered SYSREF, counts accepted beats, and holds the buffer until readout releases it.
- Drives the select lines of the 8:4 stream mux in the design wrapper and reports per-slot status.

---
 rtl/adc_buffer_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_adc_buffer_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_buffer_scheduler.sv
// Shares NBUF capture-buffer stream inputs among NCHAN ADC streams: latches requests, grants free slots round-robin.
// Latency: req_i at N -> pending_o at N+1 -> grant at N+1 -> buf_en_o at N+2 (non-aligned); done_o 1 cycle after last beat.
// Backpressure: beats count only on adc_tvalid_i[sel] & buf_tready_i[k]; a filled slot holds until release_i[k].
//
// Ports:
//   aclk, aresetn        stream clock / async active-low reset (deassertion synchronised internally)
//   req_i[NCHAN]         one-cycle capture request per channel
//   align_i              sampled at grant: 1 = start capture on the next SYSREF rising edge
//   sysref_i             SYSREF, already registered in aclk
//   adc_tvalid_i[NCHAN]  tvalid of each ADC stream
//   buf_tready_i[NBUF]   tready of each buffer stream
//   release_i[NBUF]      readout has emptied slot k
//   buf_sel_o            CW-bit channel select per slot, slot k at [CW*k +: CW]
//   buf_en_o[NBUF]       slot k forwards tvalid to its buffer
//   done_o[NBUF]         one-cycle pulse when slot k has passed CAPTURE_LEN beats
//   pending_o[NCHAN]     latched requests not yet granted
//   busy_o               any slot in use or any request pending
module adc_buffer_scheduler #(
   parameter  int NCHAN       = 8,
   parameter  int NBUF        = 4,
   parameter  int CAPTURE_LEN = 1024,
   localparam int CW          = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [NCHAN-1:0]     req_i,
   input  logic                 align_i,
   input  logic                 sysref_i,
   input  logic [NCHAN-1:0]     adc_tvalid_i,
   input  logic [NBUF-1:0]      buf_tready_i,
   input  logic [NBUF-1:0]      release_i,
   output logic [NBUF*CW-1:0]   buf_sel_o,
   output logic [NBUF-1:0]      buf_en_o,
   output logic [NBUF-1:0]      done_o,
   output logic [NCHAN-1:0]     pending_o,
   output logic                 busy_o
);

   localparam logic [15:0] LAST_BEAT = 16'(CAPTURE_LEN - 1);

   typedef enum logic [1:0] {
      S_FREE       = 2'd0,
      S_WAIT_ALIGN = 2'd1,
      S_CAPTURE    = 2'd2,
      S_HOLD       = 2'd3
   } slot_state_e;

   // Reset asserts asynchronously but is released on a clock edge, so no
   // flop sees reset removal close to aclk.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   // State
   slot_state_e       state_q [NBUF];
   slot_state_e       state_d [NBUF];
   logic [CW-1:0]     sel_q   [NBUF];
   logic [CW-1:0]     sel_d   [NBUF];
   logic [15:0]       cnt_q   [NBUF];
   logic [15:0]       cnt_d   [NBUF];
   logic [NBUF-1:0]   done_q, done_d;
   logic [NCHAN-1:0]  pending_q, pending_d;
   logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              sysref_prev_q;

   // Arbitration signals
   logic [NCHAN-1:0]  owned;
   logic [NCHAN-1:0]  eligible;
   logic [NCHAN-1:0]  chan_gnt_mask;
   logic              gnt_vld;
   logic [CW-1:0]     gnt_chan;
   logic [NBUF-1:0]   slot_gnt;
   logic              taken;
   logic              grant;
   logic              sysref_rise;
   logic [NBUF-1:0]   accept;
   logic [NBUF-1:0]   slot_busy;
   int                cand;

   assign sysref_rise = sysref_i & ~sysref_prev_q;

   // Channel pick: first pending channel from rr_ptr upward that does not
   // already own a slot. A channel that owns a slot keeps its new request
   // pending, which queues its next capture behind the current one.
   always_comb begin
      owned    = '0;
      gnt_vld  = 1'b0;
      gnt_chan = '0;
      cand     = 0;
      for (int k = 0; k < NBUF; k++) begin
         if (state_q[k] != S_FREE) begin
            owned[sel_q[k]] = 1'b1;
         end
      end
      eligible = pending_q & ~owned;
      for (int off = 0; off < NCHAN; off++) begin
         cand = (int'(rr_ptr_q) + off) % NCHAN;
         if (!gnt_vld && eligible[CW'(cand)]) begin
            gnt_vld  = 1'b1;
            gnt_chan = CW'(cand);
         end
      end
   end

   // Slot pick: lowest-index FREE slot; at most one grant per cycle.
   always_comb begin
      slot_gnt = '0;
      taken    = 1'b0;
      for (int k = 0; k < NBUF; k++) begin
         if (!taken && state_q[k] == S_FREE) begin
            slot_gnt[k] = gnt_vld;
            taken       = 1'b1;
         end
      end
      grant = |slot_gnt;
   end

   always_comb begin
      chan_gnt_mask = '0;
      if (grant) begin
         chan_gnt_mask[gnt_chan] = 1'b1;
      end
      // A new request arriving in the grant cycle re-arms pending.
      pending_d = (pending_q & ~chan_gnt_mask) | req_i;
      rr_ptr_d  = rr_ptr_q;
      if (grant) begin
         rr_ptr_d = (int'(gnt_chan) == NCHAN - 1) ? '0 : gnt_chan + 1'b1;
      end
   end

   // Per-slot FSM next state
   always_comb begin
      done_d = '0;
      accept = '0;
      for (int k = 0; k < NBUF; k++) begin
         state_d[k] = state_q[k];
         sel_d[k]   = sel_q[k];
         cnt_d[k]   = cnt_q[k];
         accept[k]  = (state_q[k] == S_CAPTURE) & adc_tvalid_i[sel_q[k]] & buf_tready_i[k];
         case (state_q[k])
            S_FREE: begin
               if (slot_gnt[k]) begin
                  sel_d[k]   = gnt_chan;
                  cnt_d[k]   = '0;
                  state_d[k] = align_i ? S_WAIT_ALIGN : S_CAPTURE;
               end
            end
            S_WAIT_ALIGN: begin
               if (sysref_rise) begin
                  state_d[k] = S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (accept[k]) begin
                  if (cnt_q[k] == LAST_BEAT) begin
                     state_d[k] = S_HOLD;
                     done_d[k]  = 1'b1;
                     cnt_d[k]   = '0;
                  end else begin
                     cnt_d[k] = cnt_q[k] + 16'd1;
                  end
               end
            end
            S_HOLD: begin
               if (release_i[k]) begin
                  state_d[k] = S_FREE;
               end
            end
            default: begin
               state_d[k] = S_FREE;
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q     <= '0;
         rr_ptr_q      <= '0;
         sysref_prev_q <= 1'b0;
         done_q        <= '0;
         for (int k = 0; k < NBUF; k++) begin
            state_q[k] <= S_FREE;
            sel_q[k]   <= '0;
            cnt_q[k]   <= '0;
         end
      end else begin
         pending_q     <= pending_d;
         rr_ptr_q      <= rr_ptr_d;
         sysref_prev_q <= sysref_i;
         done_q        <= done_d;
         for (int k = 0; k < NBUF; k++) begin
            state_q[k] <= state_d[k];
            sel_q[k]   <= sel_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   // Outputs come straight from state so reset clears them without a clock.
   always_comb begin
      buf_sel_o = '0;
      buf_en_o  = '0;
      slot_busy = '0;
      for (int k = 0; k < NBUF; k++) begin
         buf_sel_o[k*CW +: CW] = sel_q[k];
         buf_en_o[k]           = (state_q[k] == S_CAPTURE);
         slot_busy[k]          = (state_q[k] != S_FREE);
      end
   end

   assign done_o    = done_q;
   assign pending_o = pending_q;
   assign busy_o    = (|slot_busy) | (|pending_q);

endmodule

// File: tb/tb_adc_buffer_scheduler.sv
// Bench for adc_buffer_scheduler: instance A (CAPTURE_LEN=4) has its own inputs;
// instances B (CAPTURE_LEN=16) and C (CAPTURE_LEN=1) share a second input set.
// Every granted capture pushes {instance, slot, channel, beats}; done_o pops it.
module tb_adc_buffer_scheduler;

   localparam int NI = 3;

   logic aclk = 1'b0;
   logic aresetn;

   always #5 aclk = ~aclk;

   // Input sets: 0 drives A, 1 drives B and C
   logic [7:0] req_s    [2];
   logic       align_s  [2];
   logic       sysref_s [2];
   logic [7:0] tvalid_s [2];
   logic [3:0] tready_s [2];
   logic [3:0] rel_s    [2];

   logic [11:0] sel_w  [NI];
   logic [3:0]  en_w   [NI];
   logic [3:0]  done_w [NI];
   logic [7:0]  pend_w [NI];
   logic        busy_w [NI];

   adc_buffer_scheduler #(.CAPTURE_LEN(4)) u_dut_a (
      .aclk(aclk), .aresetn(aresetn), .req_i(req_s[0]), .align_i(align_s[0]),
      .sysref_i(sysref_s[0]), .adc_tvalid_i(tvalid_s[0]), .buf_tready_i(tready_s[0]),
      .release_i(rel_s[0]), .buf_sel_o(sel_w[0]), .buf_en_o(en_w[0]), .done_o(done_w[0]),
      .pending_o(pend_w[0]), .busy_o(busy_w[0]));

   adc_buffer_scheduler #(.CAPTURE_LEN(16)) u_dut_b (
      .aclk(aclk), .aresetn(aresetn), .req_i(req_s[1]), .align_i(align_s[1]),
      .sysref_i(sysref_s[1]), .adc_tvalid_i(tvalid_s[1]), .buf_tready_i(tready_s[1]),
      .release_i(rel_s[1]), .buf_sel_o(sel_w[1]), .buf_en_o(en_w[1]), .done_o(done_w[1]),
      .pending_o(pend_w[1]), .busy_o(busy_w[1]));

   adc_buffer_scheduler #(.CAPTURE_LEN(1)) u_dut_c (
      .aclk(aclk), .aresetn(aresetn), .req_i(req_s[1]), .align_i(align_s[1]),
      .sysref_i(sysref_s[1]), .adc_tvalid_i(tvalid_s[1]), .buf_tready_i(tready_s[1]),
      .release_i(rel_s[1]), .buf_sel_o(sel_w[2]), .buf_en_o(en_w[2]), .done_o(done_w[2]),
      .pending_o(pend_w[2]), .busy_o(busy_w[2]));

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      int inst;
      int slot;
      int chan;
      int beats;
   } exp_t;

   exp_t exp_q [$];
   int   beat_cnt [NI][4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic expect_cap(input int inst, input int slot, input int chan, input int beats);
      exp_t e;
      e.inst  = inst;
      e.slot  = slot;
      e.chan  = chan;
      e.beats = beats;
      exp_q.push_back(e);
   endtask

   function automatic int outstanding(input int inst);
      int n = 0;
      foreach (exp_q[e]) if (exp_q[e].inst == inst) n++;
      return n;
   endfunction

   // Scoreboard: counts beats passed by each slot and pops the matching
   // expectation when the slot reports done.
   always @(negedge aclk) begin : monitor
      int idx;
      int s;
      for (int i = 0; i < NI; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (!aresetn) begin
               beat_cnt[i][k] = 0;
            end else begin
               s = (i == 0) ? 0 : 1;
               if (done_w[i][k]) begin
                  idx = -1;
                  for (int e = 0; e < exp_q.size(); e++)
                     if (idx < 0 && exp_q[e].inst == i && exp_q[e].slot == k) idx = e;
                  if (idx < 0) begin
                     check($sformatf("unexpected_done_i%0d_s%0d", i, k), done_w[i][k], 0);
                  end else begin
                     check($sformatf("done_chan_i%0d_s%0d", i, k), sel_w[i][3*k +: 3], exp_q[idx].chan);
                     check($sformatf("done_beats_i%0d_s%0d", i, k), beat_cnt[i][k], exp_q[idx].beats);
                     exp_q.delete(idx);
                  end
                  beat_cnt[i][k] = 0;
               end
               if (en_w[i][k] && tvalid_s[s][sel_w[i][3*k +: 3]] && tready_s[s][k])
                  beat_cnt[i][k]++;
            end
         end
      end
   end

   task automatic idle_ctrl();
      for (int s = 0; s < 2; s++) begin
         req_s[s]    = '0;
         rel_s[s]    = '0;
         align_s[s]  = 1'b0;
         sysref_s[s] = 1'b0;
      end
   endtask

   // Asserts reset between clock edges; outputs must clear without a clock.
   task automatic do_reset(input int n_abort);
      check("reset_abort_count", exp_q.size(), n_abort);
      #2 aresetn = 1'b0;
      #1;
      for (int i = 0; i < NI; i++)
         check($sformatf("reset_async_i%0d", i), {sel_w[i], en_w[i], done_w[i], pend_w[i], busy_w[i]}, 0);
      exp_q.delete();
      idle_ctrl();
      step();
      step();
      aresetn = 1'b1;
      repeat (3) step();
      for (int i = 0; i < NI; i++)
         check($sformatf("post_reset_i%0d", i), {sel_w[i], en_w[i], done_w[i], pend_w[i], busy_w[i]}, 0);
   endtask

   initial begin
      aresetn = 1'b1;
      idle_ctrl();
      for (int s = 0; s < 2; s++) begin
         tvalid_s[s] = '0;
         tready_s[s] = '0;
      end
      step();
      do_reset(0);

      // ---------------- single request, CAPTURE_LEN=4
      tvalid_s[0] = 8'hFF;
      tready_s[0] = 4'hF;
      req_s[0] = 8'h04;                       // cycle N
      expect_cap(0, 0, 2, 4);
      step(); req_s[0] = '0;                  // N+1
      check("t1_pending_n1", pend_w[0], 8'h04);
      check("t1_en_n1", en_w[0], 4'h0);
      step();                                 // N+2
      check("t1_en_n2", en_w[0], 4'h1);
      check("t1_sel_n2", sel_w[0][2:0], 3'd2);
      check("t1_pending_n2", pend_w[0], 8'h00);
      check("t1_busy_n2", busy_w[0], 1'b1);
      for (int n = 3; n <= 5; n++) begin
         step();
         check($sformatf("t1_en_n%0d", n), en_w[0], 4'h1);
      end
      step();                                 // N+6
      check("t1_done_n6", done_w[0], 4'h1);
      check("t1_en_n6", en_w[0], 4'h0);
      step();                                 // N+7
      check("t1_done_n7", done_w[0], 4'h0);
      check("t1_busy_hold", busy_w[0], 1'b1);
      repeat (3) step();
      check("t1_still_hold", busy_w[0], 1'b1);
      rel_s[0] = 4'h1;
      step(); rel_s[0] = '0;
      check("t1_busy_free", busy_w[0], 1'b0);
      check("t1_sel_kept", sel_w[0], 12'h002);

      // ---------------- round-robin fairness
      do_reset(0);
      tvalid_s[0] = 8'hFF;
      tready_s[0] = 4'hF;
      req_s[0] = 8'hFF;                       // cycle M
      expect_cap(0, 0, 0, 4);
      expect_cap(0, 1, 1, 4);
      expect_cap(0, 2, 2, 4);
      expect_cap(0, 3, 3, 4);
      step(); req_s[0] = '0;                  // M+1
      check("t2_pending_m1", pend_w[0], 8'hFF);
      step();                                 // M+2
      check("t2_pending_m2", pend_w[0], 8'hFE);
      repeat (3) step();                      // M+5
      check("t2_pending_m5", pend_w[0], 8'hF0);
      check("t2_sel_m5", sel_w[0], 12'h688);
      check("t2_en_m5", en_w[0], 4'hF);
      repeat (5) step();                      // M+10
      rel_s[0] = 4'h4;
      expect_cap(0, 2, 4, 4);
      step(); rel_s[0] = '0;                  // M+11
      check("t2_en_m11", en_w[0], 4'h0);
      step();                                 // M+12
      check("t2_sel_slot2", sel_w[0][8:6], 3'd4);
      check("t2_en_m12", en_w[0], 4'h4);
      check("t2_pending_m12", pend_w[0], 8'hE0);
      step();                                 // M+13
      rel_s[0] = 4'h1;
      expect_cap(0, 0, 5, 4);
      step(); rel_s[0] = '0;                  // M+14
      step();                                 // M+15
      check("t2_sel_slot0", sel_w[0][2:0], 3'd5);
      check("t2_en_m15", en_w[0], 4'h5);
      check("t2_pending_m15", pend_w[0], 8'hC0);
      repeat (8) step();
      check("t2_pending_end", pend_w[0], 8'hC0);

      // ---------------- SYSREF alignment
      do_reset(0);
      tvalid_s[0] = 8'hFF;
      tready_s[0] = 4'hF;
      align_s[0]  = 1'b1;
      sysref_s[0] = 1'b1;
      req_s[0]    = 8'h01;                    // G-1
      expect_cap(0, 0, 0, 4);
      step(); req_s[0] = '0;                  // G (grant)
      check("t3_pending_g", pend_w[0], 8'h01);
      step(); align_s[0] = 1'b0;              // G+1
      check("t3_en_wait", en_w[0], 4'h0);
      check("t3_busy_wait", busy_w[0], 1'b1);
      repeat (4) step();                      // G+5
      check("t3_sysref_high_no_start", en_w[0], 4'h0);
      sysref_s[0] = 1'b0;
      repeat (10) step();                     // G+15
      sysref_s[0] = 1'b1;
      check("t3_en_at_edge", en_w[0], 4'h0);
      step();                                 // G+16
      check("t3_aligned_start", en_w[0], 4'h1);
      sysref_s[0] = 1'b0;
      repeat (6) step();
      rel_s[0] = 4'h1;
      step(); rel_s[0] = '0;
      check("t3_busy_free", busy_w[0], 1'b0);

      // ---------------- queued re-request
      tvalid_s[0] = 8'h00;
      req_s[0] = 8'h02;                       // Q
      expect_cap(0, 0, 1, 4);
      step(); req_s[0] = '0;                  // Q+1
      step();                                 // Q+2
      check("t5_en_q2", en_w[0], 4'h1);
      check("t5_sel_q2", sel_w[0][2:0], 3'd1);
      rel_s[0] = 4'h1;
      req_s[0] = 8'h02;
      step(); rel_s[0] = '0; req_s[0] = '0;   // Q+3
      check("t5_release_ignored", en_w[0], 4'h1);
      step();                                 // Q+4
      check("t5_pending_q4", pend_w[0], 8'h02);
      check("t5_not_second_slot", en_w[0], 4'h1);
      repeat (2) step();                      // Q+6
      check("t5_pending_q6", pend_w[0], 8'h02);
      check("t5_en_q6", en_w[0], 4'h1);
      tvalid_s[0] = 8'hFF;
      expect_cap(0, 0, 1, 4);
      repeat (4) step();                      // Q+10
      check("t5_hold_q10", en_w[0], 4'h0);
      check("t5_pending_q10", pend_w[0], 8'h02);
      rel_s[0] = 4'h1;
      step(); rel_s[0] = '0;                  // Q+11
      step();                                 // Q+12
      check("t5_regrant_en", en_w[0], 4'h1);
      check("t5_regrant_sel", sel_w[0][2:0], 3'd1);
      check("t5_regrant_pending", pend_w[0], 8'h00);
      repeat (6) step();
      rel_s[0] = 4'h1;
      step(); rel_s[0] = '0;
      check("t5_busy_free", busy_w[0], 1'b0);

      // ---------------- backpressure (B: 16 beats, C: 1 beat)
      tvalid_s[1] = '0;
      tready_s[1] = '0;
      req_s[1] = 8'h01;
      expect_cap(1, 0, 0, 16);
      expect_cap(2, 0, 0, 1);
      step(); req_s[1] = '0;
      for (int n = 0; n < 400 && (outstanding(1) + outstanding(2)) > 0; n++) begin
         tready_s[1][0] = (n % 2 == 0);
         tvalid_s[1][0] = ($urandom_range(0, 3) != 0);
         step();
      end
      check("t4_captures_done", outstanding(1) + outstanding(2), 0);
      check("t4_b_en_hold", en_w[1], 4'h0);
      check("t4_b_busy_hold", busy_w[1], 1'b1);
      rel_s[1] = 4'h1;
      step(); rel_s[1] = '0;
      check("t4_b_free", busy_w[1], 1'b0);
      check("t4_c_free", busy_w[2], 1'b0);

      // ---------------- reset mid-capture on B
      tvalid_s[1] = 8'hFF;
      tready_s[1] = 4'hF;
      req_s[1] = 8'h01;                       // T
      expect_cap(1, 0, 0, 16);
      expect_cap(2, 0, 0, 1);
      step(); req_s[1] = '0;                  // T+1
      repeat (8) step();                      // T+9: beat 7 in flight
      check("t6_beats_before_reset", beat_cnt[1][0], 7);
      check("t6_en_before_reset", en_w[1], 4'h1);
      do_reset(1);
      req_s[1] = 8'h01;
      expect_cap(1, 0, 0, 16);
      expect_cap(2, 0, 0, 1);
      step(); req_s[1] = '0;
      repeat (22) step();
      check("t6_after_reset_done", outstanding(1) + outstanding(2), 0);
      rel_s[1] = 4'h1;
      step(); rel_s[1] = '0;
      check("t6_b_free", busy_w[1], 1'b0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
